// File: rtl/recepcion_pkg.sv
// recepcion_pkg
// Shared definitions for the UART receive path.
//   CLKS_PER_BIT_DEFAULT : clk_in cycles per bit (50 MHz / 9600 baud),
//                          shared with the transmision serializer.
//   state_e              : receiver FSM state encoding (3 bits).
package recepcion_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 5208;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_e;

endpackage

// File: rtl/recepcion_if.sv
// recepcion_if
// Groups the serial line, the read acknowledge and the received-byte status
// signals of the UART receiver.
//   rx    : serial line (idle high)
//   rd    : read acknowledge from the consumer
//   dout  : last good byte
//   done  : one-cycle pulse when dout updates
//   avail : sticky byte-waiting flag
//   busy  : frame in progress
//   ferr  : one-cycle framing error pulse
//   ovr   : sticky overrun flag
// slave  : the receiver side; master : the line driver / consumer side.
interface recepcion_if;

   logic       rx;
   logic       rd;
   logic [7:0] dout;
   logic       done;
   logic       avail;
   logic       busy;
   logic       ferr;
   logic       ovr;

   modport slave (
      input  rx, rd,
      output dout, done, avail, busy, ferr, ovr
   );

   modport master (
      output rx, rd,
      input  dout, done, avail, busy, ferr, ovr
   );

endinterface

// File: rtl/recepcion_sync2.sv
// sync2
// Two-flop synchronizer for a single asynchronous input pin.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output
// RESET_VAL sets the value both flops take during reset, so an idle-high
// line does not look like an edge when reset is released.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first one a full cycle to settle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/recepcion.sv
// recepcion
// UART 8N1 receiver: deserializes the Bluetooth module's TX line into bytes.
//   clk_in : system clock
//   reset  : asynchronous active-low reset
//   bus    : recepcion_if.slave (rx, rd in; dout, done, avail, busy, ferr,
//            ovr out)
// Start bit is checked at mid-bit; data and stop bits are then sampled one
// full bit period apart, i.e. near their centres.
module recepcion
   import recepcion_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic        clk_in,
   input  logic        reset,
   recepcion_if.slave  bus
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic          rxSync;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shReg_q, shReg_d;
   logic [7:0]    dout_q, dout_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          avail_q, avail_d;
   logic          ovr_q, ovr_d;

   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk_i  (clk_in),
      .rst_ni (reset),
      .d_i    (bus.rx),
      .q_o    (rxSync)
   );

   // All receiver state lives here; reset aborts any frame in progress.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shReg_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         avail_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shReg_q <= shReg_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         avail_q <= avail_d;
         ovr_q   <= ovr_d;
      end
   end

   // Frame sequencing. done/ferr are decided on the stop-sample edge and
   // registered so they appear as single-cycle pulses right after it.
   // avail/ovr use the same-edge decision: a new byte always leaves avail
   // set, and a read in that cycle means the old byte was consumed, so no
   // overrun.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shReg_d = shReg_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxSync) state_d = START;
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxSync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               shReg_d = {rxSync, shReg_q[7:1]};
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (rxSync) begin
                  dout_d  = shReg_q;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxSync) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      avail_d = avail_q;
      ovr_d   = ovr_q;
      if (bus.rd) begin
         avail_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (done_d) begin
         avail_d = 1'b1;
         if (avail_q && !bus.rd) ovr_d = 1'b1;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.done  = done_q;
   assign bus.avail = avail_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.ferr  = ferr_q;
   assign bus.ovr   = ovr_q;

endmodule

// File: tb/tb_recepcion.sv
// tb_recepcion
// Self-checking bench for the UART receiver with CLKS_PER_BIT = 16.
// A bench-side 8N1 serializer drives rx; a negedge monitor counts done/ferr
// pulses and records when they happen.
module tb_recepcion;

   localparam int CPB = 16;
   // Pin falling edge to done visible: 2 synchronizer edges + leave IDLE,
   // then CPB/2 + 9*CPB to the stop sample.
   localparam int DONE_LAT = 3 + CPB / 2 + 9 * CPB;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      logic       rdAfter;
      logic [7:0] expDout;
      logic       expAvail;
      logic       expOvr;
      int         expDone;
      int         expFerr;
   } vec_t;

   logic clk;
   logic reset;
   recepcion_if bus ();

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int doneCnt = 0;
   int ferrCnt = 0;
   int lastDoneCyc = 0;
   logic availAtDone = 1'b0;
   logic ovrAtDone   = 1'b0;
   int startCyc = 0;

   vec_t vecs [6];

   recepcion #(.CLKS_PER_BIT(CPB)) dut (
      .clk_in (clk),
      .reset  (reset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.done) begin
         doneCnt     <= doneCnt + 1;
         lastDoneCyc <= cyc;
         availAtDone <= bus.avail;
         ovrAtDone   <= bus.ovr;
      end
      if (bus.ferr) ferrCnt <= ferrCnt + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // 8N1 serializer; leaves rx at the stop-bit level on return.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      startCyc = cyc;
      bus.rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.rx = data[i];
         waitCycles(CPB);
      end
      bus.rx = stopBit;
      waitCycles(CPB);
   endtask

   task automatic pulseRead();
      bus.rd = 1'b1;
      waitCycles(1);
      bus.rd = 1'b0;
   endtask

   initial begin
      int d0, f0;

      vecs[0] = '{8'h33, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1, 0};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1, 0};
      vecs[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1, 0};
      vecs[3] = '{8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1, 0};
      vecs[4] = '{8'h55, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1};
      vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1, 0};

      reset  = 1'b0;
      bus.rx = 1'b1;
      bus.rd = 1'b0;
      waitCycles(3);
      checkOutput("rst dout",  {24'd0, bus.dout}, 32'h0);
      checkOutput("rst done",  {31'd0, bus.done},  32'h0);
      checkOutput("rst avail", {31'd0, bus.avail}, 32'h0);
      checkOutput("rst busy",  {31'd0, bus.busy},  32'h0);
      checkOutput("rst ferr",  {31'd0, bus.ferr},  32'h0);
      checkOutput("rst ovr",   {31'd0, bus.ovr},   32'h0);
      reset = 1'b1;
      waitCycles(3);

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         d0 = doneCnt;
         f0 = ferrCnt;
         applyStimulus(vecs[i].data, vecs[i].stopBit);
         bus.rx = 1'b1;
         waitCycles(6);
         checkOutput($sformatf("v%0d dout", i), {24'd0, bus.dout}, {24'd0, vecs[i].expDout});
         checkOutput($sformatf("v%0d avail", i), {31'd0, bus.avail}, {31'd0, vecs[i].expAvail});
         checkOutput($sformatf("v%0d ovr", i), {31'd0, bus.ovr}, {31'd0, vecs[i].expOvr});
         checkOutput($sformatf("v%0d done cnt", i), doneCnt - d0, vecs[i].expDone);
         checkOutput($sformatf("v%0d ferr cnt", i), ferrCnt - f0, vecs[i].expFerr);
         checkOutput($sformatf("v%0d busy", i), {31'd0, bus.busy}, 32'h0);
         if (vecs[i].expDone == 1)
            checkOutput($sformatf("v%0d done latency", i), lastDoneCyc - startCyc, DONE_LAT);
         if (vecs[i].rdAfter) begin
            pulseRead();
            checkOutput($sformatf("v%0d avail after rd", i), {31'd0, bus.avail}, 32'h0);
            checkOutput($sformatf("v%0d ovr after rd", i), {31'd0, bus.ovr}, 32'h0);
         end
      end

      // Read sampled on the same edge that produces done (avail already 1).
      d0 = doneCnt;
      fork
         applyStimulus(8'h3C, 1'b1);
         begin
            repeat (DONE_LAT - 1) @(posedge clk);
            #1 bus.rd = 1'b1;
            @(posedge clk);
            #1 bus.rd = 1'b0;
         end
      join
      waitCycles(2);
      checkOutput("rd@done done cnt", doneCnt - d0, 1);
      checkOutput("rd@done avail at done", {31'd0, availAtDone}, 32'h1);
      checkOutput("rd@done ovr at done", {31'd0, ovrAtDone}, 32'h0);
      checkOutput("rd@done avail after", {31'd0, bus.avail}, 32'h1);
      checkOutput("rd@done ovr after", {31'd0, bus.ovr}, 32'h0);
      checkOutput("rd@done dout", {24'd0, bus.dout}, 32'h3C);
      pulseRead();
      checkOutput("clear avail", {31'd0, bus.avail}, 32'h0);

      // Short low glitch on an idle line.
      d0 = doneCnt;
      f0 = ferrCnt;
      bus.rx = 1'b0;
      waitCycles(5);
      checkOutput("glitch busy in start", {31'd0, bus.busy}, 32'h1);
      bus.rx = 1'b1;
      waitCycles(20);
      checkOutput("glitch busy after", {31'd0, bus.busy}, 32'h0);
      checkOutput("glitch done cnt", doneCnt - d0, 0);
      checkOutput("glitch ferr cnt", ferrCnt - f0, 0);

      // Framing error followed by a held-low line.
      d0 = doneCnt;
      f0 = ferrCnt;
      applyStimulus(8'h55, 1'b0);
      bus.rx = 1'b0;
      waitCycles(40);
      checkOutput("break busy held", {31'd0, bus.busy}, 32'h1);
      checkOutput("break ferr cnt", ferrCnt - f0, 1);
      checkOutput("break done cnt", doneCnt - d0, 0);
      checkOutput("break dout", {24'd0, bus.dout}, 32'h3C);
      checkOutput("break avail", {31'd0, bus.avail}, 32'h0);
      bus.rx = 1'b1;
      waitCycles(6);
      checkOutput("break busy released", {31'd0, bus.busy}, 32'h0);
      checkOutput("break no 0x00 frames", doneCnt - d0, 0);

      // Reset during data bit 4 of 0xFF, then a clean 0x0F.
      d0 = doneCnt;
      f0 = ferrCnt;
      fork
         applyStimulus(8'hFF, 1'b1);
         begin
            waitCycles(85);
            reset = 1'b0;
            waitCycles(3);
            checkOutput("midrst dout",  {24'd0, bus.dout}, 32'h0);
            checkOutput("midrst done",  {31'd0, bus.done},  32'h0);
            checkOutput("midrst avail", {31'd0, bus.avail}, 32'h0);
            checkOutput("midrst busy",  {31'd0, bus.busy},  32'h0);
            checkOutput("midrst ferr",  {31'd0, bus.ferr},  32'h0);
            checkOutput("midrst ovr",   {31'd0, bus.ovr},   32'h0);
            reset = 1'b1;
         end
      join
      bus.rx = 1'b1;
      waitCycles(6);
      checkOutput("aborted done cnt", doneCnt - d0, 0);
      checkOutput("aborted ferr cnt", ferrCnt - f0, 0);
      applyStimulus(8'h0F, 1'b1);
      bus.rx = 1'b1;
      waitCycles(6);
      checkOutput("post-rst dout", {24'd0, bus.dout}, 32'h0F);
      checkOutput("post-rst done cnt", doneCnt - d0, 1);
      checkOutput("post-rst avail", {31'd0, bus.avail}, 32'h1);
      checkOutput("post-rst latency", lastDoneCyc - startCyc, DONE_LAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
